// File: rtl/gp_writeback_pkg.sv
// gp_writeback_pkg: shared widths, register indices and arbiter encodings for the write-back stage
package gp_writeback_pkg;
    localparam int DATA_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 2;
    localparam int NUM_GP_REGS    = 4;
    localparam int FIFO_DEPTH     = 4;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_A = 2'd0;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_B = 2'd1;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_C = 2'd2;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_D = 2'd3;
    typedef enum logic {WB_SRC_ALU = 1'b0, WB_SRC_MEM = 1'b1} wb_src_e;
endpackage

// File: rtl/gp_writeback_fifo.sv
// gp_writeback_fifo: synchronous in-order FIFO holding {dest, data} write-back entries
module gp_writeback_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/gp_writeback.sv
// gp_writeback: round-robin arbitrates ALU/load results, buffers them in order and
// retires one gp_registers write per cycle while publishing per-register pending bits
module gp_writeback #(
    parameter int DATA_WIDTH     = gp_writeback_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = gp_writeback_pkg::REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = gp_writeback_pkg::FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0]       alu_dest,
    input  logic [DATA_WIDTH-1:0]           alu_data,
    output logic                            alu_ready,
    input  logic                            mem_valid,
    input  logic [REG_ADDR_WIDTH-1:0]       mem_dest,
    input  logic [DATA_WIDTH-1:0]           mem_data,
    output logic                            mem_ready,
    input  logic                            wb_stall,
    output logic                            write_enable,
    output logic [REG_ADDR_WIDTH-1:0]       store_at,
    output logic [DATA_WIDTH-1:0]           alu_result,
    output logic [(1<<REG_ADDR_WIDTH)-1:0]  pending,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    import gp_writeback_pkg::*;
    localparam int NR = 1 << REG_ADDR_WIDTH;
    localparam int EW = DATA_WIDTH + REG_ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH + 2);
    wb_src_e                   last_src;
    logic                      full, empty, accept, load, pop, out_valid, alu_grant;
    logic [REG_ADDR_WIDTH-1:0] in_dest, out_dest;
    logic [DATA_WIDTH-1:0]     in_data, out_data;
    logic [EW-1:0]             head;
    // ALU wins when it is alone or when the load unit was granted last
    assign alu_grant    = alu_valid & (~mem_valid | (last_src == WB_SRC_MEM));
    assign alu_ready    = reset & ~full & alu_grant;
    assign mem_ready    = reset & ~full & mem_valid & ~alu_grant;
    assign accept       = alu_ready | mem_ready;
    assign in_dest      = mem_ready ? mem_dest : alu_dest;
    assign in_data      = mem_ready ? mem_data : alu_data;
    assign write_enable = out_valid & ~wb_stall;
    assign store_at     = out_valid ? out_dest : '0;
    assign alu_result   = out_valid ? out_data : '0;
    // an empty output stage refills even under stall, giving FIFO_DEPTH+1 capacity
    assign load         = write_enable | ~out_valid;
    assign pop          = load & ~empty;

    gp_writeback_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .wdata ({in_dest, in_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            out_valid <= 1'b0;
            out_dest  <= '0;
            out_data  <= '0;
            last_src  <= WB_SRC_ALU;
        end else begin
            if (load) out_valid <= ~empty;
            if (pop) begin
                out_dest <= head[EW-1:DATA_WIDTH];
                out_data <= head[DATA_WIDTH-1:0];
            end
            if (accept) last_src <= mem_ready ? WB_SRC_MEM : WB_SRC_ALU;
        end

    for (genvar r = 0; r < NR; r++) begin : g_pend
        logic [CW-1:0] cnt;
        logic          inc, dec;
        assign inc        = accept & (in_dest == REG_ADDR_WIDTH'(r));
        assign dec        = write_enable & (out_dest == REG_ADDR_WIDTH'(r));
        assign pending[r] = |cnt;
        always_ff @(posedge clk or negedge reset)
            if (!reset) cnt <= '0;
            else if (inc != dec) cnt <= inc ? cnt + 1'b1 : cnt - 1'b1;
        a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(inc && !dec && (&cnt)));
        a_no_underflow: assert property (@(posedge clk) disable iff (!reset) !(dec && !inc && cnt == '0));
    end
endmodule

// File: tb/tb_gp_writeback.sv
// tb_gp_writeback: directed vector table plus hand sequences for stall fill, WAW and mid-run reset
module tb_gp_writeback;
    import gp_writeback_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 0, mem_valid = 0, wb_stall = 0;
    logic [1:0]  alu_dest = 0, mem_dest = 0;
    logic [15:0] alu_data = 0, mem_data = 0;
    logic        alu_ready, mem_ready, write_enable;
    logic [1:0]  store_at;
    logic [15:0] alu_result;
    logic [3:0]  pending;
    logic [2:0]  fifo_count;
    logic [15:0] regs [4];
    int checks = 0;
    int failures = 0;

    gp_writeback dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_stall(wb_stall), .write_enable(write_enable), .store_at(store_at),
        .alu_result(alu_result), .pending(pending), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // stand-in for gp_registers
    always @(posedge clk or negedge reset)
        if (!reset) for (int i = 0; i < 4; i++) regs[i] <= '0;
        else if (write_enable) regs[store_at] <= alu_result;

    typedef struct packed {
        logic        av;
        logic [1:0]  ad;
        logic [15:0] adata;
        logic        mv;
        logic [1:0]  md;
        logic [15:0] mdata;
        logic        st;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [1:0]  e_sa;
        logic [15:0] e_res;
        logic [3:0]  e_pend;
        logic [2:0]  e_cnt;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [1:0] ad, input logic [15:0] adata,
                         input logic mv, input logic [1:0] md, input logic [15:0] mdata, input logic st);
        alu_valid = av; alu_dest = ad; alu_data = adata;
        mem_valid = mv; mem_dest = md; mem_data = mdata; wb_stall = st;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 0, 16'h0, 0, 0, 16'h0, 0,      0, 0, 0, 0, 16'h0, 4'b0000, 3'd0};
        vecs[1]  = '{1, REG_C, 16'h1234, 0, 0, 16'h0, 0, 1, 0, 0, 0, 16'h0, 4'b0000, 3'd0};
        vecs[2]  = '{0, 0, 16'h0, 0, 0, 16'h0, 0,      0, 0, 0, 0, 16'h0, 4'b0100, 3'd1};
        vecs[3]  = '{0, 0, 16'h0, 0, 0, 16'h0, 0,      0, 0, 1, 2, 16'h1234, 4'b0100, 3'd0};
        vecs[4]  = '{0, 0, 16'h0, 0, 0, 16'h0, 0,      0, 0, 0, 0, 16'h0, 4'b0000, 3'd0};
        vecs[5]  = '{1, REG_A, 16'h00AA, 1, REG_B, 16'h00BB, 0, 0, 1, 0, 0, 16'h0, 4'b0000, 3'd0};
        vecs[6]  = '{1, REG_A, 16'h00AA, 1, REG_C, 16'h00CC, 0, 1, 0, 0, 0, 16'h0, 4'b0010, 3'd1};
        vecs[7]  = '{0, 0, 16'h0, 1, REG_C, 16'h00CC, 0, 0, 1, 1, 1, 16'h00BB, 4'b0011, 3'd1};
        vecs[8]  = '{0, 0, 16'h0, 0, 0, 16'h0, 0,      0, 0, 1, 0, 16'h00AA, 4'b0101, 3'd1};
        vecs[9]  = '{0, 0, 16'h0, 0, 0, 16'h0, 0,      0, 0, 1, 2, 16'h00CC, 4'b0100, 3'd0};
        vecs[10] = '{0, 0, 16'h0, 0, 0, 16'h0, 0,      0, 0, 0, 0, 16'h0, 4'b0000, 3'd0};

        // T1: reset held with producers offering
        #1 reset = 0;
        drive(1, REG_B, 16'h5555, 1, REG_C, 16'h6666, 0);
        repeat (3) tick();
        chk("t1_alu_ready", alu_ready, 0);
        chk("t1_mem_ready", mem_ready, 0);
        chk("t1_we", write_enable, 0);
        chk("t1_store_at", store_at, 0);
        chk("t1_result", alu_result, 0);
        chk("t1_pending", pending, 0);
        chk("t1_count", fifo_count, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        tick();
        chk("t1_pending_rel", pending, 0);
        chk("t1_we_rel", write_enable, 0);

        // T2/T3: single write, contention and round-robin
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].adata, vecs[i].mv, vecs[i].md, vecs[i].mdata, vecs[i].st);
            #1;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            chk($sformatf("v%0d_mem_ready", i), mem_ready, vecs[i].e_mr);
            chk($sformatf("v%0d_we", i), write_enable, vecs[i].e_we);
            chk($sformatf("v%0d_store_at", i), store_at, vecs[i].e_sa);
            chk($sformatf("v%0d_result", i), alu_result, vecs[i].e_res);
            chk($sformatf("v%0d_pending", i), pending, vecs[i].e_pend);
            chk($sformatf("v%0d_count", i), fifo_count, vecs[i].e_cnt);
            if (i == 4) chk("t2_reg_c", regs[REG_C], 16'h1234);
            tick();
        end
        chk("t3_reg_a", regs[REG_A], 16'h00AA);
        chk("t3_reg_b", regs[REG_B], 16'h00BB);
        chk("t3_reg_c", regs[REG_C], 16'h00CC);

        // T4: stall fills FIFO plus output stage, then drains back-to-back
        for (int i = 0; i < 6; i++) begin
            drive(1, 2'(i % 4), 16'h0100 + 16'(i), 0, 0, 0, 1);
            #1;
            chk($sformatf("t4_ready%0d", i), alu_ready, i < 5);
            chk($sformatf("t4_we%0d", i), write_enable, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("t4_count_full", fifo_count, 4);
        chk("t4_we_stalled", write_enable, 0);
        chk("t4_pending", pending, 4'hF);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_drain_we%0d", k), write_enable, 1);
            chk($sformatf("t4_drain_sa%0d", k), store_at, k % 4);
            chk($sformatf("t4_drain_res%0d", k), alu_result, 16'h0100 + k);
            tick();
        end
        chk("t4_we_done", write_enable, 0);
        chk("t4_pending_done", pending, 0);
        chk("t4_count_done", fifo_count, 0);
        chk("t4_reg_a", regs[REG_A], 16'h0104);
        chk("t4_reg_d", regs[REG_D], 16'h0103);

        // T5: WAW on register D
        drive(1, REG_D, 16'h1111, 0, 0, 0, 0);
        #1;
        chk("t5_ready1", alu_ready, 1);
        chk("t5_pend0", pending, 0);
        tick();
        drive(1, REG_D, 16'h2222, 0, 0, 0, 0);
        #1;
        chk("t5_ready2", alu_ready, 1);
        chk("t5_pend1", pending, 4'b1000);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_we1", write_enable, 1);
        chk("t5_res1", alu_result, 16'h1111);
        chk("t5_pend2", pending, 4'b1000);
        tick();
        chk("t5_we2", write_enable, 1);
        chk("t5_res2", alu_result, 16'h2222);
        chk("t5_pend3", pending, 4'b1000);
        tick();
        chk("t5_pend4", pending, 0);
        chk("t5_we_done", write_enable, 0);
        chk("t5_reg_d", regs[REG_D], 16'h2222);

        // T6: asynchronous reset discards buffered work
        drive(1, REG_A, 16'h0A0A, 0, 0, 0, 1);
        tick();
        drive(1, REG_B, 16'h0B0B, 0, 0, 0, 1);
        tick();
        drive(1, REG_C, 16'h0C0C, 0, 0, 0, 1);
        tick();
        drive(1, REG_A, 16'h0D0D, 0, 0, 0, 1);
        #1;
        chk("t6_count_pre", fifo_count, 2);
        chk("t6_pending_pre", pending, 4'b0111);
        reset = 0;
        #1;
        chk("t6_alu_ready", alu_ready, 0);
        chk("t6_we", write_enable, 0);
        chk("t6_store_at", store_at, 0);
        chk("t6_result", alu_result, 0);
        chk("t6_pending", pending, 0);
        chk("t6_count", fifo_count, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t6_idle_we%0d", k), write_enable, 0);
        end
        chk("t6_pending_after", pending, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
